seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a DIGITS-position common-select 7-segment display. It owns one shared hex-to-segment decoder and schedules it across digit positions, one time slot per position, with a blanking guard between slots to suppress ghosting. New display values arrive through a valid/ready write port. They are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the CPU's display register and the board pins.

## Interface
- DIGITS, 4, number of digit positions (2..8)
- PRESCALE, 50000, clock cycles per digit slot; must be ≥ BLANK_CYCLES+1
- BLANK_CYCLES, 2, guard cycles at the start of each slot (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- wr_valid  in  1  write request
- wr_ready  out  1  controller can accept a write
- wr_data  in  4*DIGITS  nibble i = hex value of digit i; digit 0 is least significant
- blank_mask  in  DIGITS  bit i set = position i is never lit; sampled live every cycle
- seg  out  7  segment pattern, active high, registered
- dig_en  out  DIGITS  one-hot digit select, active high, registered
- frame_done  out  1  one-cycle pulse at each frame start

## Operation
- Registers:
  - shadow (4*DIGITS)
  - active (4*DIGITS)
  - pending flag
  - slot index (0..DIGITS-1)
  - phase counter (0..PRESCALE-1)
  - state
- States:
  - BLANK: lasts BLANK_CYCLES cycles; dig_en=0, seg=0.
  - SHOW: lasts PRESCALE-BLANK_CYCLES cycles.
    - dig_en = 1<<slot and seg = decode(active nibble[slot]).
    - If blank_mask[slot] is set, dig_en=0 and seg=0 instead.
  - BLANK→SHOW when the counter reaches BLANK_CYCLES-1.
  - SHOW→BLANK when the counter reaches PRESCALE-1; the slot then increments.
- Wrap-around: leaving SHOW of slot DIGITS-1 takes the machine to slot 0, BLANK. On that same edge:
  - active ← shadow if pending is set.
  - pending clears.
  - frame_done is 1 for the first cycle of slot 0 BLANK.
- Write handshake:
  - The transfer happens on a cycle with wr_valid && wr_ready.
  - The transfer loads shadow ← wr_data and sets pending.
  - wr_ready = !pending.
  - While pending, further writes stall; wr_data is not sampled.
- Simultaneous events: if a transfer lands on the commit edge, the commit uses the old shadow. The new data sets pending and commits at the following frame boundary.
- Decode table (4-bit value → 7-bit seg):
  - 0:0111111, 1:0000011, 2:1101101, 3:1001111
  - 4:1010011, 5:1011110, 6:1111110, 7:0000111
  - 8:1111111, 9:1011111, A:1110111, B:1111010
  - C:0111100, D:1101011, E:1111100, F:1110100
- Reset (rst_n low at a rising edge):
  - state=BLANK, slot=0, counter=0
  - active=0, shadow=0, pending=0
  - seg=0, dig_en=0, frame_done=0, wr_ready=1
- Reset mid-frame discards any pending write and restarts at slot 0 BLANK. No frame_done pulse for that restart.

## Timing
- Frame period = DIGITS*PRESCALE cycles, independent of blank_mask and writes.
- After reset release, dig_en first goes to 1 after BLANK_CYCLES cycles.
- Outputs are registered: seg/dig_en reflect the state entered at the same edge.
- No combinational path from any input to any output.
- wr_ready falls the cycle after an accepted write. It rises the cycle after the commit edge.
- Write-to-visible latency: at most DIGITS*PRESCALE + BLANK_CYCLES cycles; at least BLANK_CYCLES+1 cycles.

## Configuration
- SEG_SCAN_LEADING_ZERO_EN defined: leading-zero suppression.
  - In SHOW, position i>0 is forced dark (dig_en=0, seg=0) when every active nibble from i up to DIGITS-1 is zero.
  - Position 0 is always shown.
  - Suppression is computed from active, never from shadow.
- Undefined: every unmasked position is shown, including leading zeros.

## Structure
- Package seg_pkg holds:
  - the state enum typedef (BLANK, SHOW)
  - the 16-entry segment table constant
  - the function returning seg for a nibble
- Sub-module hex_seg_lut: combinational nibble→seg lookup from seg_pkg, one instance, fed by the slot mux.
- Timer, FSM, buffers and leading-zero logic stay in seg_scan_ctrl.

## Test plan
Settings: DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
- Reset:
  - Stimulus: rst_n low 3 cycles, then release.
  - Response during reset: seg=0, dig_en=0, wr_ready=1.
  - Response after release: dig_en=0001 and seg=0111111 appear on the 3rd cycle; dig_en=0010 on the 11th cycle.
- Frame-boundary commit:
  - Stimulus: write 16'h8F10 in slot 1.
  - Response: wr_ready=0 next cycle; display stays 0000 for the rest of the frame.
  - Next frame slots 0..3 show seg 0111111, 0000011, 1110100, 1111111.
  - wr_ready=1 the cycle after the commit.
- Back-pressure:
  - Stimulus: second write 16'h1234 held valid while pending.
  - Response: not accepted until wr_ready rises; it then commits one frame later and slots show 4,3,2,1.
- Blank mask:
  - Stimulus: blank_mask=0100.
  - Response: dig_en[2] never asserts; frame_done still every 32 cycles; slots 0, 1 and 3 unchanged.
- Reset mid-frame:
  - Stimulus: rst_n low during slot 2 SHOW with a write pending.
  - Response: pending lost; after release the display shows 0000 and wr_ready=1.
- Leading-zero suppression (macro defined):
  - Data 16'h0050: slots 3 and 2 dark, slot 1 shows 1011110, slot 0 shows 0111111.
  - Data 16'h0000: only slot 0 lit.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: scan FSM states and hex-to-segment table shared by the scan controller.
package seg_pkg;
  typedef enum logic {BLANK, SHOW} state_t;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000011, 7'b1101101, 7'b1001111,
    7'b1010011, 7'b1011110, 7'b1111110, 7'b0000111,
    7'b1111111, 7'b1011111, 7'b1110111, 7'b1111010,
    7'b0111100, 7'b1101011, 7'b1111100, 7'b1110100
  };
  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    return SEG_TABLE[v];
  endfunction
endpackage

// File: rtl/hex_seg_lut.sv
// hex_seg_lut: combinational nibble to 7-segment lookup.
module hex_seg_lut
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex2seg(nib_i);
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan with blanking guard and frame-aligned double buffer.
// Define SEG_SCAN_LEADING_ZERO_EN to darken leading zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);
  localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);
  state_t                state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   active_q, active_d, shadow_q, shadow_d;
  logic                  pend_q, pend_d;
  logic [6:0]            seg_q, seg_d, lut_seg;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic                  fd_q;
  logic                  last, slot_end, wrap, xfer, lz, dark;
  logic [3:0]            nib;
  // Outputs are computed from next-state values so they align with the state register.
  always_comb begin
    last     = cnt_q == CW'(PRESCALE - 1);
    cnt_d    = last ? '0 : cnt_q + 1'b1;
    slot_end = state_q == SHOW && last;
    wrap     = slot_end && slot_q == SW'(DIGITS - 1);
    state_d  = (state_q == BLANK && cnt_q == CW'(BLANK_CYCLES - 1)) ? SHOW : slot_end ? BLANK : state_q;
    slot_d   = wrap ? '0 : slot_end ? slot_q + 1'b1 : slot_q;
    xfer     = wr_valid && !pend_q;
    shadow_d = xfer ? wr_data : shadow_q;
    active_d = (wrap && pend_q) ? shadow_q : active_q;
    pend_d   = xfer || (pend_q && !wrap);
    nib      = active_d[4*slot_d +: 4];
    dark     = state_d == BLANK || blank_mask[slot_d] || lz;
    seg_d    = dark ? '0 : lut_seg;
    dig_d    = dark ? '0 : DIGITS'(1) << slot_d;
  end
`ifdef SEG_SCAN_LEADING_ZERO_EN
  logic [DIGITS-1:0] zf;
  for (genvar g = 0; g < DIGITS; g++) begin : g_lz
    assign zf[g] = (active_d >> (4 * g)) == '0;
  end
  assign lz = slot_d != '0 && zf[slot_d];
`else
  assign lz = 1'b0;
`endif
  hex_seg_lut u_lut (.nib_i(nib), .seg_o(lut_seg));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BLANK;
      slot_q   <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      seg_q    <= '0;
      dig_q    <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      fd_q     <= wrap;
    end
  end
  assign wr_ready   = !pend_q;
  assign seg        = seg_q;
  assign dig_en     = dig_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed checks of seg_scan_ctrl against a frame-position model.
module tb_seg_scan_ctrl;
  localparam int D = 4, P = 8, B = 2, F = D * P;
  localparam logic [6:0] TBL [16] = '{
    7'b0111111, 7'b0000011, 7'b1101101, 7'b1001111,
    7'b1010011, 7'b1011110, 7'b1111110, 7'b0000111,
    7'b1111111, 7'b1011111, 7'b1110111, 7'b1111010,
    7'b0111100, 7'b1101011, 7'b1111100, 7'b1110100
  };
  logic clk = 0, rst_n = 0, wr_valid = 0, wr_ready, frame_done;
  logic [15:0] wr_data = 0;
  logic [3:0] blank_mask = 0, dig_en;
  logic [6:0] seg;
  int checks = 0, errors = 0, n = 0;
  logic [15:0] m_act = 0, m_sh = 0;
  bit m_pend = 0;
  logic [3:0] m_mask = 0;

  seg_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .blank_mask(blank_mask), .seg(seg), .dig_en(dig_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model: n edges since reset release; frame position is n mod F, commits at position 0.
  function automatic logic [13:0] expv();
    int p, s;
    bit dark;
    p = n % F;
    s = p / P;
    dark = n == 0 || p % P < B || m_mask[s];
`ifdef SEG_SCAN_LEADING_ZERO_EN
    if (s > 0 && (m_act >> (4 * s)) == 0) dark = 1;
`endif
    return {dark ? 7'd0 : TBL[m_act[4*s +: 4]], dark ? 4'd0 : 4'(1 << s), n > 0 && p == 0, !m_pend};
  endfunction

  task automatic step();
    bit x;
    x = wr_valid && !m_pend;
    @(posedge clk);
    if (!rst_n) begin
      n = 0; m_act = '0; m_sh = '0; m_pend = 0;
    end else begin
      n++;
      if (n % F == 0) begin
        if (m_pend) m_act = m_sh;
        m_pend = 0;
      end
      if (x) begin m_sh = wr_data; m_pend = 1; end
    end
    m_mask = blank_mask;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) begin
      step();
      checks++;
      if ({seg, dig_en, frame_done, wr_ready} !== 13'b1) begin
        errors++; $display("FAIL reset_hold: got %b want %b", {seg, dig_en, frame_done, wr_ready}, 13'b1);
      end
    end
    rst_n = 1;
    repeat (12) begin
      step();
      checks++;
      if ({seg, dig_en, frame_done, wr_ready} !== expv()) begin
        errors++; $display("FAIL reset_run n=%0d: got %b want %b", n, {seg, dig_en, frame_done, wr_ready}, expv());
      end
      if (n == 2) begin
        checks++;
        if ({dig_en, seg} !== {4'b0001, 7'b0111111}) begin
          errors++; $display("FAIL first_show: got %b want %b", {dig_en, seg}, {4'b0001, 7'b0111111});
        end
      end
      if (n == 10) begin
        checks++;
        if (dig_en !== 4'b0010) begin
          errors++; $display("FAIL second_slot: got %b want 0010", dig_en);
        end
      end
    end
  endtask

  task automatic test_commit();
    logic [6:0] want [4] = '{7'b0111111, 7'b0000011, 7'b1110100, 7'b1111111};
    for (int k = 0; k < F + 1 && n % F != 9; k++) step();
    wr_valid = 1; wr_data = 16'h8F10;
    step();
    wr_valid = 0;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL commit_ready_low: got %b want 0", wr_ready); end
    for (int k = 0; k < F + 1 && n % F != 0; k++) begin
      step();
      checks++;
      if ({seg, dig_en, frame_done, wr_ready} !== expv()) begin
        errors++; $display("FAIL commit_hold n=%0d: got %b want %b", n, {seg, dig_en, frame_done, wr_ready}, expv());
      end
    end
    checks++;
    if ({wr_ready, frame_done} !== 2'b11) begin
      errors++; $display("FAIL commit_edge: got %b want 11", {wr_ready, frame_done});
    end
    repeat (F) begin
      step();
      checks++;
      if ({seg, dig_en, frame_done, wr_ready} !== expv()) begin
        errors++; $display("FAIL commit_frame n=%0d: got %b want %b", n, {seg, dig_en, frame_done, wr_ready}, expv());
      end
      if (n % P == B) begin
        checks++;
        if (seg !== want[(n % F) / P]) begin
          errors++; $display("FAIL commit_digit slot %0d: got %b want %b", (n % F) / P, seg, want[(n % F) / P]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] want [4] = '{7'b1010011, 7'b1001111, 7'b1101101, 7'b0000011};
    wr_valid = 1; wr_data = 16'h5555;
    step();
    wr_data = 16'h1234;
    for (int k = 0; k < 2 * F && m_sh != 16'h1234; k++) begin
      step();
      checks++;
      if ({seg, dig_en, frame_done, wr_ready} !== expv()) begin
        errors++; $display("FAIL b2b_hold n=%0d: got %b want %b", n, {seg, dig_en, frame_done, wr_ready}, expv());
      end
    end
    wr_valid = 0;
    for (int k = 0; k < 2 * F && !(m_act == 16'h1234 && n % F == 0); k++) begin
      step();
      checks++;
      if ({seg, dig_en, frame_done, wr_ready} !== expv()) begin
        errors++; $display("FAIL b2b_wait n=%0d: got %b want %b", n, {seg, dig_en, frame_done, wr_ready}, expv());
      end
    end
    checks++;
    if (m_act != 16'h1234) begin errors++; $display("FAIL b2b_timeout: got %h want 1234", m_act); end
    repeat (F) begin
      step();
      if (n % P == B) begin
        checks++;
        if (seg !== want[(n % F) / P]) begin
          errors++; $display("FAIL b2b_digit slot %0d: got %b want %b", (n % F) / P, seg, want[(n % F) / P]);
        end
      end
    end
  endtask

  task automatic test_blank_mask();
    int fd_cnt = 0;
    bit lit2 = 0;
    blank_mask = 4'b0100;
    repeat (2 * F) begin
      step();
      fd_cnt += int'(frame_done);
      lit2 |= dig_en[2];
      checks++;
      if ({seg, dig_en, frame_done, wr_ready} !== expv()) begin
        errors++; $display("FAIL mask n=%0d: got %b want %b", n, {seg, dig_en, frame_done, wr_ready}, expv());
      end
    end
    checks++;
    if (fd_cnt != 2 || lit2) begin
      errors++; $display("FAIL mask_summary: got frames=%0d lit2=%0d want frames=2 lit2=0", fd_cnt, lit2);
    end
    blank_mask = 0;
  endtask

  task automatic test_random();
    repeat (400) begin
      wr_valid = $urandom_range(0, 3) == 0;
      wr_data = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
      step();
      checks++;
      if ({seg, dig_en, frame_done, wr_ready} !== expv()) begin
        errors++; $display("FAIL random n=%0d: got %b want %b", n, {seg, dig_en, frame_done, wr_ready}, expv());
      end
    end
    wr_valid = 0; blank_mask = 0;
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < F + 1 && n % F != 1; k++) step();
    wr_valid = 1; wr_data = 16'hABCD;
    step();
    wr_valid = 0;
    for (int k = 0; k < F && n % F != 20; k++) step();
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL midreset_pending: got %b want 0", wr_ready); end
    rst_n = 0;
    step();
    rst_n = 1;
    repeat (2 * F) begin
      step();
      checks++;
      if ({seg, dig_en, frame_done, wr_ready} !== expv()) begin
        errors++; $display("FAIL midreset n=%0d: got %b want %b", n, {seg, dig_en, frame_done, wr_ready}, expv());
      end
      if (n % F == B) begin
        checks++;
        if ({seg, wr_ready} !== {7'b0111111, 1'b1}) begin
          errors++; $display("FAIL midreset_zero: got %b want %b", {seg, wr_ready}, {7'b0111111, 1'b1});
        end
      end
    end
  endtask

`ifdef SEG_SCAN_LEADING_ZERO_EN
  task automatic test_leading_zero();
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    logic [10:0] want [2][4] = '{
      '{{4'b0001, 7'b0111111}, {4'b0010, 7'b1011110}, 11'd0, 11'd0},
      '{{4'b0001, 7'b0111111}, 11'd0, 11'd0, 11'd0}};
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < F + 1 && m_pend; k++) step();
      wr_valid = 1; wr_data = vals[v];
      step();
      wr_valid = 0;
      for (int k = 0; k < 2 * F && !(m_act == vals[v] && !m_pend && n % F == 0); k++) step();
      repeat (F) begin
        step();
        if (n % P == B) begin
          checks++;
          if ({dig_en, seg} !== want[v][(n % F) / P]) begin
            errors++; $display("FAIL lz %h slot %0d: got %b want %b", vals[v], (n % F) / P, {dig_en, seg}, want[v][(n % F) / P]);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_commit();
    test_back_to_back();
    test_blank_mask();
    test_random();
    test_reset_midframe();
`ifdef SEG_SCAN_LEADING_ZERO_EN
    test_leading_zero();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
